// File: rtl/wb_port_arbiter_pkg.sv
// Shared register-file constants used by the write-back port arbiter.
package wb_port_arbiter_pkg;
  localparam int WORD_WIDTH     = 32;
  localparam int REG_FILE_DEPTH = 16;
  localparam int REG_ADDR_W     = $clog2(REG_FILE_DEPTH);
endpackage

// File: rtl/wb_late_fifo.sv
// Circular buffer for late write-back results with per-entry valid bits
// and a kill-by-destination port for younger pipeline writes.
module wb_late_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [AW-1:0]             push_dest,
  input  logic [DW-1:0]             push_value,
  input  logic                      pop,
  input  logic                      kill,
  input  logic [AW-1:0]             kill_dest,
  output logic                      head_valid,
  output logic [AW-1:0]             head_dest,
  output logic [DW-1:0]             head_value,
  output logic [PW-1:0]             rd_ptr,
  output logic [DEPTH-1:0]          ent_valid,
  output logic [DEPTH-1:0][AW-1:0]  ent_dest,
  output logic [CW-1:0]             count,
  output logic                      empty,
  output logic                      full
);
  logic [DEPTH-1:0][DW-1:0] val_q;
  logic [DEPTH-1:0][AW-1:0] dest_q;
  logic [DEPTH-1:0]         vld_q;
  logic [PW-1:0]            wr_q, rd_q;
  logic [CW-1:0]            cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q  <= '0;
      dest_q <= '0;
      vld_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && vld_q[i] && dest_q[i] == kill_dest) vld_q[i] <= 1'b0;
        if (pop && rd_q == PW'(i)) vld_q[i] <= 1'b0;
        // The push slot is never an occupied slot, so it cannot collide with kill/pop.
        if (push && wr_q == PW'(i)) begin
          vld_q[i]  <= 1'b1;
          dest_q[i] <= push_dest;
          val_q[i]  <= push_value;
        end
      end
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_valid = vld_q[rd_q];
  assign head_dest  = dest_q[rd_q];
  assign head_value = val_q[rd_q];
  assign rd_ptr     = rd_q;
  assign ent_valid  = vld_q;
  assign ent_dest   = dest_q;
  assign count      = cnt_q;
  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CW'(DEPTH));
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline WB (always wins) and
// buffered late results; reports pending destinations and requests stalls.
module wb_port_arbiter #(
  parameter int WORD_WIDTH   = wb_port_arbiter_pkg::WORD_WIDTH,
  parameter int REG_ADDR_W   = wb_port_arbiter_pkg::REG_ADDR_W,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_wb_en,
  input  logic [REG_ADDR_W-1:0] pipe_wb_dest,
  input  logic [WORD_WIDTH-1:0] pipe_wb_value,
  input  logic                  late_valid,
  output logic                  late_ready,
  input  logic [REG_ADDR_W-1:0] late_dest,
  input  logic [WORD_WIDTH-1:0] late_value,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  output logic                  pend_hit1,
  output logic                  pend_hit2,
  output logic                  stall_req,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_dest,
  output logic [WORD_WIDTH-1:0] rf_value
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIM     = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] LIM_M1  = SW'(STARVE_LIMIT - 1);

  logic                                 head_valid, fifo_empty, fifo_full;
  logic [REG_ADDR_W-1:0]                head_dest;
  logic [WORD_WIDTH-1:0]                head_value;
  logic [PW-1:0]                        rd_ptr;
  logic [FIFO_DEPTH-1:0]                ent_valid;
  logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] ent_dest;
  logic [CW-1:0]                        fifo_count;
  logic                                 pop, bypass, push, late_kill;
  logic [SW-1:0]                        starve_cnt;

  // Head leaves in any idle slot; a killed head is simply discarded.
  assign pop       = !pipe_wb_en && !fifo_empty;
  assign bypass    = !pipe_wb_en && fifo_empty && late_valid;
  assign late_ready = (fifo_count < DEPTH_C) || bypass;
  assign late_kill = pipe_wb_en && (late_dest == pipe_wb_dest);
  assign push      = late_valid && late_ready && !bypass && !late_kill;

  wb_late_fifo #(.DEPTH(FIFO_DEPTH), .DW(WORD_WIDTH), .AW(REG_ADDR_W)) u_fifo (
    .clk, .rst,
    .push, .push_dest(late_dest), .push_value(late_value),
    .pop, .kill(pipe_wb_en), .kill_dest(pipe_wb_dest),
    .head_valid, .head_dest, .head_value, .rd_ptr,
    .ent_valid, .ent_dest,
    .count(fifo_count), .empty(fifo_empty), .full(fifo_full)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_dest  = pipe_wb_dest;
    rf_value = pipe_wb_value;
    if (pipe_wb_en) begin
      rf_we = 1'b1;
    end else if (pop) begin
      rf_we    = head_valid;
      rf_dest  = head_dest;
      rf_value = head_value;
    end else if (bypass) begin
      rf_we    = 1'b1;
      rf_dest  = late_dest;
      rf_value = late_value;
    end
    if (!rst) rf_we = 1'b0;
  end

  // The head being written this cycle no longer counts as pending.
  always_comb begin
    pend_hit1 = late_valid && (late_dest == src1);
    pend_hit2 = late_valid && (late_dest == src2);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i] && !(pop && rd_ptr == PW'(i))) begin
        if (ent_dest[i] == src1) pend_hit1 = 1'b1;
        if (ent_dest[i] == src2) pend_hit2 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      if (!fifo_full)                          starve_cnt <= '0;
      else if (pipe_wb_en && starve_cnt != LIM) starve_cnt <= starve_cnt + 1'b1;
      stall_req <= fifo_full && (stall_req || (pipe_wb_en && starve_cnt == LIM_M1));
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed table-driven bench for wb_port_arbiter plus a mid-operation reset sequence.
module tb_wb_port_arbiter;
  logic        clk, rst;
  logic        pipe_wb_en, late_valid, late_ready;
  logic [3:0]  pipe_wb_dest, late_dest, src1, src2, rf_dest;
  logic [31:0] pipe_wb_value, late_value, rf_value;
  logic        pend_hit1, pend_hit2, stall_req, rf_we;

  int n_vec = 0;
  int n_bad = 0;

  wb_port_arbiter dut (
    .clk(clk), .rst(rst),
    .pipe_wb_en(pipe_wb_en), .pipe_wb_dest(pipe_wb_dest), .pipe_wb_value(pipe_wb_value),
    .late_valid(late_valid), .late_ready(late_ready), .late_dest(late_dest), .late_value(late_value),
    .src1(src1), .src2(src2), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .stall_req(stall_req), .rf_we(rf_we), .rf_dest(rf_dest), .rf_value(rf_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pe;  logic [3:0] pd; logic [31:0] pv;
    logic        lv;  logic [3:0] ld; logic [31:0] lval;
    logic [3:0]  s1, s2;
    logic        we;  logic [3:0] d;  logic [31:0] v;
    logic        lr, h1, h2, st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic pe, input logic [3:0] pd, input logic [31:0] pv,
                     input logic lv, input logic [3:0] ld, input logic [31:0] lval,
                     input logic [3:0] s1, input logic [3:0] s2,
                     input logic we, input logic [3:0] d, input logic [31:0] v,
                     input logic lr, input logic h1, input logic h2, input logic st);
    vec_t t;
    t.pe = pe; t.pd = pd; t.pv = pv; t.lv = lv; t.ld = ld; t.lval = lval;
    t.s1 = s1; t.s2 = s2; t.we = we; t.d = d; t.v = v;
    t.lr = lr; t.h1 = h1; t.h2 = h2; t.st = st;
    tbl.push_back(t);
  endtask

  task automatic drive(input logic pe, input logic [3:0] pd, input logic [31:0] pv,
                       input logic lv, input logic [3:0] ld, input logic [31:0] lval,
                       input logic [3:0] s1, input logic [3:0] s2);
    pipe_wb_en = pe; pipe_wb_dest = pd; pipe_wb_value = pv;
    late_valid = lv; late_dest = ld; late_value = lval;
    src1 = s1; src2 = s2;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  initial begin
    logic bad;
    drive(1, 4'd1, 32'h1, 1, 4'd2, 32'h2, 4'd2, 4'd0);
    rst = 1'b0;
    #1;
    chk("reset_rf_we", {31'b0, rf_we}, 32'd0);
    chk("reset_stall", {31'b0, stall_req}, 32'd0);
    chk("reset_late_ready", {31'b0, late_ready}, 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // pe pd pv | lv ld lval | s1 s2 | we d v | lr h1 h2 st
    add(0, 0, 0,        0, 0, 0,        0, 0,   0, 0, 0,        1, 0, 0, 0);
    add(0, 0, 0,        1, 3, 'hA5,     3, 4,   1, 3, 'hA5,     1, 1, 0, 0);
    add(1, 1, 'h11,     1, 2, 'h22,     2, 1,   1, 1, 'h11,     1, 1, 0, 0);
    add(0, 0, 0,        0, 0, 0,        2, 1,   1, 2, 'h22,     1, 0, 0, 0);
    add(0, 0, 0,        0, 0, 0,        2, 1,   0, 0, 0,        1, 0, 0, 0);
    add(1, 1, 'h101,    1, 6, 'h66,     6, 0,   1, 1, 'h101,    1, 1, 0, 0);
    add(1, 1, 'h102,    1, 7, 'h77,     6, 7,   1, 1, 'h102,    1, 1, 1, 0);
    add(1, 1, 'h103,    0, 0, 0,        7, 6,   1, 1, 'h103,    0, 1, 1, 0);
    add(1, 1, 'h104,    0, 0, 0,        7, 6,   1, 1, 'h104,    0, 1, 1, 0);
    add(1, 1, 'h105,    0, 0, 0,        7, 6,   1, 1, 'h105,    0, 1, 1, 0);
    add(1, 1, 'h106,    0, 0, 0,        7, 6,   1, 1, 'h106,    0, 1, 1, 0);
    add(1, 1, 'h107,    1, 8, 'h88,     8, 0,   1, 1, 'h107,    0, 1, 0, 1);
    add(0, 0, 0,        0, 0, 0,        6, 7,   1, 6, 'h66,     0, 0, 1, 1);
    add(0, 0, 0,        0, 0, 0,        7, 6,   1, 7, 'h77,     1, 0, 0, 1);
    add(0, 0, 0,        0, 0, 0,        7, 6,   0, 0, 0,        1, 0, 0, 0);
    add(1, 1, 'h201,    1, 5, 'h55,     5, 0,   1, 1, 'h201,    1, 1, 0, 0);
    add(1, 5, 'h77,     0, 0, 0,        5, 0,   1, 5, 'h77,     1, 1, 0, 0);
    add(0, 0, 0,        0, 0, 0,        5, 0,   0, 0, 0,        1, 0, 0, 0);
    add(0, 0, 0,        0, 0, 0,        5, 0,   0, 0, 0,        1, 0, 0, 0);
    add(1, 9, 'h99,     1, 9, 'h55,     9, 0,   1, 9, 'h99,     1, 1, 0, 0);
    add(0, 0, 0,        0, 0, 0,        9, 0,   0, 0, 0,        1, 0, 0, 0);
    add(1, 10, 'hA0,    1, 11, 'hBB,    11, 0,  1, 10, 'hA0,    1, 1, 0, 0);
    add(0, 0, 0,        1, 12, 'hCC,    12, 11, 1, 11, 'hBB,    1, 1, 0, 0);
    add(0, 0, 0,        0, 0, 0,        12, 11, 1, 12, 'hCC,    1, 0, 0, 0);
    add(0, 0, 0,        0, 0, 0,        12, 11, 0, 0, 0,        1, 0, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].pe, tbl[i].pd, tbl[i].pv, tbl[i].lv, tbl[i].ld, tbl[i].lval, tbl[i].s1, tbl[i].s2);
      #1;
      n_vec++;
      bad = (rf_we !== tbl[i].we) || (tbl[i].we && (rf_dest !== tbl[i].d || rf_value !== tbl[i].v))
         || (late_ready !== tbl[i].lr) || (pend_hit1 !== tbl[i].h1) || (pend_hit2 !== tbl[i].h2)
         || (stall_req !== tbl[i].st);
      if (bad) begin
        n_bad++;
        $display("FAIL vec%0d: got we=%b dest=%0d val=%0h lr=%b h1=%b h2=%b st=%b, expected we=%b dest=%0d val=%0h lr=%b h1=%b h2=%b st=%b",
                 i, rf_we, rf_dest, rf_value, late_ready, pend_hit1, pend_hit2, stall_req,
                 tbl[i].we, tbl[i].d, tbl[i].v, tbl[i].lr, tbl[i].h1, tbl[i].h2, tbl[i].st);
      end
    end

    // Fill the buffer with the pipe busy until stall_req rises, then reset mid-flight.
    @(negedge clk); drive(1, 4'd1, 32'h301, 1, 4'd2, 32'h22, 4'd0, 4'd0);
    @(negedge clk); drive(1, 4'd1, 32'h302, 1, 4'd3, 32'h33, 4'd0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drive(1, 4'd1, 32'h310 + k, 0, 4'd0, 32'h0, 4'd0, 4'd0);
    end
    @(negedge clk); drive(1, 4'd1, 32'h320, 0, 4'd0, 32'h0, 4'd2, 4'd3);
    #1;
    chk("pre_reset_stall", {31'b0, stall_req}, 32'd1);
    chk("pre_reset_ready", {31'b0, late_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midreset_rf_we", {31'b0, rf_we}, 32'd0);
    chk("midreset_stall", {31'b0, stall_req}, 32'd0);
    chk("midreset_ready", {31'b0, late_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 4'd2, 4'd3);
    #1;
    chk("post_reset_we0", {31'b0, rf_we}, 32'd0);
    chk("post_reset_pend1", {31'b0, pend_hit1}, 32'd0);
    chk("post_reset_pend2", {31'b0, pend_hit2}, 32'd0);
    @(negedge clk); #1;
    chk("post_reset_we1", {31'b0, rf_we}, 32'd0);
    chk("post_reset_ready", {31'b0, late_ready}, 32'd1);
    chk("post_reset_stall", {31'b0, stall_req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
